// File: rtl/aggr_cdma_scheduler.sv
// Frame scheduler for a CDMA aggregation datapath.
// Admits requesting ports at frame boundaries, sequences the spreading
// chips of each frame, and tracks when the adder-tree sum of each chip
// emerges from the pipelined tree.
//
// Handshake: a port raises req_i and holds it until it sees its grant_o
// bit; grant_o is a one-cycle pulse coinciding with frame_start_o, and
// req_i is only sampled at a frame boundary, so a request raised mid-frame
// waits for the next boundary.
module aggr_cdma_scheduler #(
    parameter int NUM_PORTS       = 8,
    parameter int CDMA_CODE_WIDTH = 8,
    parameter int ADDER_LATENCY   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              grant_o,
    output logic [NUM_PORTS-1:0]              active_mask_o,
    output logic [$clog2(CDMA_CODE_WIDTH)-1:0] chip_idx_o,
    output logic                              chip_valid_o,
    output logic                              frame_start_o,
    output logic                              chip_last_o,
    output logic                              sum_valid_o,
    output logic                              sum_last_o,
    output logic                              busy_o,
    output logic [1:0]                        state_o
);

    localparam int CHIP_W  = $clog2(CDMA_CODE_WIDTH);
    localparam int DRAIN_W = $clog2(ADDER_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [NUM_PORTS-1:0]   mask_q;
    logic [CHIP_W-1:0]      chip_idx_q;
    logic                   chip_valid_q;
    logic                   frame_start_q;
    logic                   chip_last_q;
    logic                   busy_q;
    logic [DRAIN_W-1:0]     drain_cnt_q;
    logic [ADDER_LATENCY-1:0] sv_pipe_q, sv_pipe_d;
    logic [ADDER_LATENCY-1:0] sl_pipe_q, sl_pipe_d;

    logic start_ok;
    assign start_ok = enable_i && (|req_i);

    // Frame sequencer: admission, chip counting, drain of the adder tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            mask_q        <= '0;
            chip_idx_q    <= '0;
            chip_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            chip_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            grant_q       <= '0;
            frame_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q       <= S_RUN;
                        busy_q        <= 1'b1;
                        grant_q       <= req_i;
                        mask_q        <= req_i;
                        chip_idx_q    <= '0;
                        chip_valid_q  <= 1'b1;
                        frame_start_q <= 1'b1;
                        chip_last_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (chip_last_q) begin
                        if (start_ok) begin
                            // Next frame follows with no bubble.
                            grant_q       <= req_i;
                            mask_q        <= req_i;
                            chip_idx_q    <= '0;
                            frame_start_q <= 1'b1;
                            chip_last_q   <= 1'b0;
                        end else begin
                            state_q      <= S_DRAIN;
                            mask_q       <= '0;
                            chip_idx_q   <= '0;
                            chip_valid_q <= 1'b0;
                            chip_last_q  <= 1'b0;
                            drain_cnt_q  <= '0;
                        end
                    end else begin
                        chip_idx_q  <= chip_idx_q + 1'b1;
                        chip_last_q <= (chip_idx_q == CHIP_W'(CDMA_CODE_WIDTH - 2));
                    end
                end
                S_DRAIN: begin
                    // Wait out the adder-tree latency before going idle.
                    if (drain_cnt_q == DRAIN_W'(ADDER_LATENCY - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next value of the sum delay lines: shift in this cycle's chip flags.
    always_comb begin
        sv_pipe_d    = '0;
        sl_pipe_d    = '0;
        sv_pipe_d[0] = chip_valid_q;
        sl_pipe_d[0] = chip_last_q;
        for (int i = 1; i < ADDER_LATENCY; i++) begin
            sv_pipe_d[i] = sv_pipe_q[i-1];
            sl_pipe_d[i] = sl_pipe_q[i-1];
        end
    end

    // Delay lines mirroring the adder-tree depth, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_pipe_q <= '0;
            sl_pipe_q <= '0;
        end else begin
            sv_pipe_q <= sv_pipe_d;
            sl_pipe_q <= sl_pipe_d;
        end
    end

    assign grant_o       = grant_q;
    assign active_mask_o = mask_q;
    assign chip_idx_o    = chip_idx_q;
    assign chip_valid_o  = chip_valid_q;
    assign frame_start_o = frame_start_q;
    assign chip_last_o   = chip_last_q;
    assign sum_valid_o   = sv_pipe_q[ADDER_LATENCY-1];
    assign sum_last_o    = sl_pipe_q[ADDER_LATENCY-1];
    assign busy_o        = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_aggr_cdma_scheduler.sv
// Bench for aggr_cdma_scheduler: a default instance (8/8/3) and a wide
// instance (16/16/4) share clock, reset and stimulus. Expected output
// traces come from a frame-level timeline model.
module tb_aggr_cdma_scheduler;

    localparam int MAXC = 256;

    typedef struct packed {
        logic [15:0] grant;
        logic [15:0] mask;
        logic [3:0]  idx;
        logic        cv;
        logic        fs;
        logic        cl;
        logic        sv;
        logic        sl;
        logic        busy;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] req;

    logic [7:0]  g8, m8;
    logic [2:0]  i8;
    logic        cv8, fs8, cl8, sv8, sl8, b8;
    logic [1:0]  st8;
    logic [15:0] g16, m16;
    logic [3:0]  i16;
    logic        cv16, fs16, cl16, sv16, sl16, b16;
    logic [1:0]  st16;

    logic        en_hist[MAXC];
    logic [15:0] req_hist[MAXC];
    obs_t        obs8[MAXC], obs16[MAXC], exp8[MAXC], exp16[MAXC], exp_m[MAXC];

    int n_checks;
    int n_fail;

    aggr_cdma_scheduler #(.NUM_PORTS(8), .CDMA_CODE_WIDTH(8), .ADDER_LATENCY(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .req_i(req[7:0]),
        .grant_o(g8), .active_mask_o(m8), .chip_idx_o(i8), .chip_valid_o(cv8),
        .frame_start_o(fs8), .chip_last_o(cl8), .sum_valid_o(sv8), .sum_last_o(sl8),
        .busy_o(b8), .state_o(st8)
    );

    aggr_cdma_scheduler #(.NUM_PORTS(16), .CDMA_CODE_WIDTH(16), .ADDER_LATENCY(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .req_i(req),
        .grant_o(g16), .active_mask_o(m16), .chip_idx_o(i16), .chip_valid_o(cv16),
        .frame_start_o(fs16), .chip_last_o(cl16), .sum_valid_o(sv16), .sum_last_o(sl16),
        .busy_o(b16), .state_o(st16)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t snap8();
        obs_t o;
        o = '0;
        o.grant = {8'h00, g8};
        o.mask  = {8'h00, m8};
        o.idx   = {1'b0, i8};
        o.cv = cv8; o.fs = fs8; o.cl = cl8; o.sv = sv8; o.sl = sl8; o.busy = b8;
        return o;
    endfunction

    function automatic obs_t snap16();
        obs_t o;
        o = '0;
        o.grant = g16;
        o.mask  = m16;
        o.idx   = i16;
        o.cv = cv16; o.fs = fs16; o.cl = cl16; o.sv = sv16; o.sl = sl16; o.busy = b16;
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            en_hist[c]  = 1'b0;
            req_hist[c] = '0;
        end
    endtask

    // Observe cycle i at its negedge, then drive the inputs for edge i+1.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs8[i]  = snap8();
            obs16[i] = snap16();
            if (i + 1 < n) begin
                enable = en_hist[i+1];
                req    = req_hist[i+1];
            end
        end
        enable = 1'b0;
        req    = '0;
    endtask

    // Timeline model: a frame admitted at edge e occupies chips e..e+cw-1;
    // each chip's sum appears lat cycles later; at the boundary edge e+cw
    // the next frame follows directly if admitted, otherwise lat drain
    // cycles run and the earliest new admission is edge e+cw+lat+1.
    task automatic run_model(input int n, input int cw, input int lat, input logic [15:0] pm);
        int e;
        logic [15:0] r;
        for (int c = 0; c < MAXC; c++) exp_m[c] = '0;
        e = 0;
        while (e < n) begin
            r = req_hist[e] & pm;
            if (en_hist[e] && r != 16'h0) begin
                for (int k = 0; k < cw; k++) begin
                    if (e + k < n) begin
                        exp_m[e+k].idx  = 4'(k);
                        exp_m[e+k].cv   = 1'b1;
                        exp_m[e+k].mask = r;
                        exp_m[e+k].busy = 1'b1;
                        exp_m[e+k].fs   = (k == 0);
                        exp_m[e+k].cl   = (k == cw - 1);
                        if (k == 0) exp_m[e+k].grant = r;
                    end
                    if (e + k + lat < n) begin
                        exp_m[e+k+lat].sv = 1'b1;
                        exp_m[e+k+lat].sl = (k == cw - 1);
                    end
                end
                e = e + cw;
                if (!(e < n && en_hist[e] && (req_hist[e] & pm) != 16'h0)) begin
                    for (int k = 0; k < lat; k++) if (e + k < n) exp_m[e+k].busy = 1'b1;
                    e = e + lat + 1;
                end
            end else begin
                e++;
            end
        end
    endtask

    task automatic build_expect(input int n);
        run_model(n, 8, 3, 16'h00FF);
        exp8 = exp_m;
        run_model(n, 16, 4, 16'hFFFF);
        exp16 = exp_m;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        o = snap8();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_dut8: got %h expected 0", o); end
        o = snap16();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_dut16: got %h expected 0", o); end
        n_checks++;
        if (st8 !== 2'd0 || st16 !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d/%0d expected 0/0", st8, st16);
        end
        enable = 1'b0;
        req    = '0;
        rst_n  = 1'b1;
        clear_stim();
        capture(6);
        build_expect(6);
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL reset_idle dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL reset_idle dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
    endtask

    task automatic test_single_frame();
        int busy_cnt, sv_cnt;
        do_reset();
        clear_stim();
        en_hist[1] = 1'b1;
        for (int c = 1; c < 40; c++) req_hist[c] = 16'h0005;
        capture(40);
        build_expect(40);
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL single_frame dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL single_frame dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
        busy_cnt = 0;
        sv_cnt   = 0;
        for (int c = 0; c < 40; c++) begin
            busy_cnt += int'(obs8[c].busy);
            sv_cnt   += int'(obs8[c].sv);
        end
        n_checks++;
        if (busy_cnt != 11) begin n_fail++; $display("FAIL single_frame_busy_len: got %0d expected 11", busy_cnt); end
        n_checks++;
        if (sv_cnt != 8) begin n_fail++; $display("FAIL single_frame_sum_len: got %0d expected 8", sv_cnt); end
        n_checks++;
        if (obs8[11].sl !== 1'b1 || obs8[8].cl !== 1'b1) begin
            n_fail++; $display("FAIL single_frame_last: got cl=%b sl=%b expected 1 1", obs8[8].cl, obs8[11].sl);
        end
        n_checks++;
        if (obs16[16].idx !== 4'd15 || obs16[16].cl !== 1'b1 || obs16[20].sl !== 1'b1) begin
            n_fail++; $display("FAIL sweep_last: got idx=%0d cl=%b sl=%b expected 15 1 1", obs16[16].idx, obs16[16].cl, obs16[20].sl);
        end
    endtask

    task automatic test_back_to_back();
        int sv_cnt, g_cnt;
        do_reset();
        clear_stim();
        for (int c = 1; c < 60; c++) begin
            en_hist[c]  = 1'b1;
            req_hist[c] = 16'hFFFF;
        end
        capture(60);
        build_expect(60);
        for (int c = 0; c < 60; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL back_to_back dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL back_to_back dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
        sv_cnt = 0;
        g_cnt  = 0;
        for (int c = 4; c < 60; c++) sv_cnt += int'(obs8[c].sv);
        for (int c = 0; c < 60; c++) g_cnt += int'(obs8[c].grant != 16'h0);
        n_checks++;
        if (sv_cnt != 56) begin n_fail++; $display("FAIL b2b_sum_continuous: got %0d expected 56", sv_cnt); end
        n_checks++;
        if (g_cnt != 8) begin n_fail++; $display("FAIL b2b_grant_count: got %0d expected 8", g_cnt); end
    endtask

    task automatic test_late_request();
        int early;
        logic [15:0] want;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            clear_stim();
            for (int c = 1; c <= 12; c++) en_hist[c] = 1'b1;
            for (int c = 1; c < 30; c++) begin
                if (c == 1 || v == 1) req_hist[c][0] = 1'b1;
                if (c >= 4 && c <= 9) req_hist[c][3] = 1'b1;
            end
            capture(30);
            build_expect(30);
            for (int c = 0; c < 30; c++) begin
                n_checks++;
                if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL late_request%0d dut8 cycle %0d: got %h expected %h", v, c, obs8[c], exp8[c]); end
                n_checks++;
                if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL late_request%0d dut16 cycle %0d: got %h expected %h", v, c, obs16[c], exp16[c]); end
            end
            early = 0;
            for (int c = 0; c < 9; c++) early += int'(obs8[c].grant[3]);
            n_checks++;
            if (early != 0) begin n_fail++; $display("FAIL late_request%0d_early_grant: got %0d expected 0", v, early); end
            want = (v == 1) ? 16'h0009 : 16'h0008;
            n_checks++;
            if (obs8[9].mask !== want || obs8[9].grant !== want) begin
                n_fail++; $display("FAIL late_request%0d_next_mask: got mask=%h grant=%h expected %h", v, obs8[9].mask, obs8[9].grant, want);
            end
        end
    endtask

    task automatic test_enable_drop();
        int busy_cnt, g_cnt;
        do_reset();
        clear_stim();
        for (int c = 1; c <= 5; c++) en_hist[c] = 1'b1;
        for (int c = 1; c < 30; c++) req_hist[c] = 16'hFFFF;
        capture(30);
        build_expect(30);
        for (int c = 0; c < 30; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL enable_drop dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL enable_drop dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
        busy_cnt = 0;
        g_cnt    = 0;
        for (int c = 0; c < 30; c++) begin
            busy_cnt += int'(obs8[c].busy);
            g_cnt    += int'(obs8[c].grant != 16'h0);
        end
        n_checks++;
        if (busy_cnt != 11 || g_cnt != 1) begin
            n_fail++; $display("FAIL enable_drop_summary: got busy=%0d grants=%0d expected 11 1", busy_cnt, g_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o8, o16;
        do_reset();
        clear_stim();
        en_hist[1] = 1'b1;
        for (int c = 1; c < 7; c++) req_hist[c] = 16'h0005;
        capture(7);
        build_expect(7);
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL pre_reset dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL pre_reset dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
        // Chip 5 is on the outputs now; reset without any clock edge.
        rst_n = 1'b0;
        #1;
        o8  = snap8();
        o16 = snap16();
        n_checks++;
        if (o8 !== '0 || o16 !== '0) begin
            n_fail++; $display("FAIL async_reset: got %h / %h expected 0 / 0", o8, o16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_stim();
        en_hist[3] = 1'b1;
        for (int c = 3; c < 30; c++) req_hist[c] = 16'h000A;
        capture(30);
        build_expect(30);
        for (int c = 0; c < 30; c++) begin
            n_checks++;
            if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL post_reset dut8 cycle %0d: got %h expected %h", c, obs8[c], exp8[c]); end
            n_checks++;
            if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL post_reset dut16 cycle %0d: got %h expected %h", c, obs16[c], exp16[c]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            clear_stim();
            r = '0;
            for (int c = 1; c < 200; c++) begin
                for (int p = 0; p < 16; p++) begin
                    if (r[p]) begin
                        if ($urandom_range(0, 5) == 0) r[p] = 1'b0;
                    end else begin
                        if ($urandom_range(0, 7) == 0) r[p] = 1'b1;
                    end
                end
                req_hist[c] = r;
                en_hist[c]  = ($urandom_range(0, 9) < 7);
            end
            capture(200);
            build_expect(200);
            for (int c = 0; c < 200; c++) begin
                n_checks++;
                if (obs8[c] !== exp8[c]) begin n_fail++; $display("FAIL random%0d dut8 cycle %0d: got %h expected %h", round, c, obs8[c], exp8[c]); end
                n_checks++;
                if (obs16[c] !== exp16[c]) begin n_fail++; $display("FAIL random%0d dut16 cycle %0d: got %h expected %h", round, c, obs16[c], exp16[c]); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_late_request();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
